// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and FIPS-197 reference round keys
// for the AES-128 round-key store.
package aes_pkg;

    localparam int unsigned NR     = 10;
    localparam int unsigned KW     = 128;
    localparam int unsigned RIDX_W = 4;

    localparam logic [RIDX_W-1:0] RIDX_MAX = RIDX_W'(NR);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        FULL   = 2'd2,
        LOCKED = 2'd3
    } rks_state_e;

    // Expanded schedule of cipher key 2b7e1516_28aed2a6_abf71588_09cf4f3c
    localparam logic [KW-1:0] FIPS_RK [NR+1] = '{
        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
        128'ha0fafe17_88542cb1_23a33939_2a6c7605,
        128'hf2c295f2_7a96b943_5935807a_7359f67f,
        128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
        128'hef44a541_a8525b7f_b671253b_db0bad00,
        128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
        128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
        128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
        128'head27321_b58dbad2_312bf560_7f8d292f,
        128'hac7766f3_19fadc21_28d12941_575c006e,
        128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
    };

endpackage

// File: rtl/aes_round_key_store_if.sv
// Key-load, write, lock and read signals between the key-expansion
// pipeline / round unit (master) and the round-key store (slave).
interface aes_round_key_store_if;
    import aes_pkg::*;

    logic              key_load;
    logic              rk_valid;
    logic [RIDX_W-1:0] rk_round;
    logic [KW-1:0]     rk_data;
    logic              rk_ready;
    logic              lock;
    logic              keys_ready;
    logic              rd_en;
    logic [RIDX_W-1:0] rd_round;
    logic [KW-1:0]     rd_data;
    logic              rd_valid;
    logic              load_rej;
    logic              err_range;
    logic              err_dup;

    modport master (
        output key_load, rk_valid, rk_round, rk_data, lock, rd_en, rd_round,
        input  rk_ready, keys_ready, rd_data, rd_valid, load_rej, err_range, err_dup
    );

    modport slave (
        input  key_load, rk_valid, rk_round, rk_data, lock, rd_en, rd_round,
        output rk_ready, keys_ready, rd_data, rd_valid, load_rej, err_range, err_dup
    );

endinterface

// File: rtl/aes_rk_bank.sv
// (NR+1) x KW round-key register array: one write port, one registered
// read port. Storage is not reset; only the read register is.
module aes_rk_bank
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RIDX_W-1:0] waddr,
    input  logic [KW-1:0]     wdata,
    input  logic              re,
    input  logic [RIDX_W-1:0] raddr,
    output logic [KW-1:0]     rdata
);

    logic [KW-1:0] mem [NR+1];

    // Callers only assert we/re with an address in 0..NR.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/aes_round_key_store.sv
// Collects the NR+1 AES round keys into a local bank and serves them by
// round index; the bank is locked while the round unit has a block in flight.
module aes_round_key_store
    import aes_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    aes_round_key_store_if.slave        bus
);

    rks_state_e  state, state_nxt;
    logic [NR:0] mask, mask_nxt;
    logic [NR:0] wr_sel;
    logic        wr_req, wr_range, wr_ok, wr_dup;
    logic        rd_range, rd_ok;

    assign bus.rk_ready   = (state == FILL);
    assign bus.keys_ready = (state == FULL) || (state == LOCKED);

    // key_load takes priority over a same-cycle write, which is dropped.
    assign wr_req   = bus.rk_valid && (state == FILL) && !bus.key_load;
    assign wr_range = wr_req && (bus.rk_round > RIDX_MAX);
    assign wr_ok    = wr_req && !wr_range;

    assign rd_range = bus.rd_en && (bus.rd_round > RIDX_MAX);
    assign rd_ok    = bus.rd_en && bus.keys_ready && !rd_range;

    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i <= NR; i++) begin
            if (wr_ok && (bus.rk_round == RIDX_W'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    assign wr_dup = |(wr_sel & mask);

    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        unique case (state)
            IDLE: begin
                if (bus.key_load) begin
                    state_nxt = FILL;
                    mask_nxt  = '0;
                end
            end
            FILL: begin
                if (bus.key_load) begin
                    mask_nxt = '0;
                end else begin
                    if (mask == '1) begin
                        state_nxt = FULL;
                    end
                    mask_nxt = mask | wr_sel;
                end
            end
            FULL: begin
                if (bus.lock) begin
                    state_nxt = LOCKED;
                end else if (bus.key_load) begin
                    state_nxt = FILL;
                    mask_nxt  = '0;
                end
            end
            LOCKED: begin
                if (!bus.lock) begin
                    state_nxt = FULL;
                end
            end
            default: begin
                state_nxt = IDLE;
                mask_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mask          <= '0;
            bus.rd_valid  <= 1'b0;
            bus.load_rej  <= 1'b0;
            bus.err_range <= 1'b0;
            bus.err_dup   <= 1'b0;
        end else begin
            state         <= state_nxt;
            mask          <= mask_nxt;
            bus.rd_valid  <= rd_ok;
            bus.load_rej  <= bus.key_load && (state == LOCKED);
            bus.err_range <= wr_range || rd_range;
            bus.err_dup   <= wr_dup;
        end
    end

    aes_rk_bank u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (bus.rk_round),
        .wdata (bus.rk_data),
        .re    (rd_ok),
        .raddr (bus.rd_round),
        .rdata (bus.rd_data)
    );

endmodule
